// File: rtl/wall_collision_unit_if.sv
// Bundles the ball-state inputs and the collision event outputs of the wall collision unit.
interface wall_collision_unit_if #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 8
);
  logic               en;
  logic               frame_tick;
  logic               relaunch;
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic               dx_neg;
  logic               dy_neg;
  logic               left_hit;
  logic               right_hit;
  logic               top_hit;
  logic               bottom_miss;
  logic               ball_lost;
  logic [CNT_W-1:0]   hit_count;

  modport master (
    output en, frame_tick, relaunch, ball_x, ball_y, dx_neg, dy_neg,
    input  left_hit, right_hit, top_hit, bottom_miss, ball_lost, hit_count
  );

  modport slave (
    input  en, frame_tick, relaunch, ball_x, ball_y, dx_neg, dy_neg,
    output left_hit, right_hit, top_hit, bottom_miss, ball_lost, hit_count
  );
endinterface

// File: rtl/wall_collision_unit.sv
// Breakout playfield-boundary collision detector: per-frame wall hit pulses with holdoff,
// bottom-miss detection with a LOST state, and a saturating wall-hit counter.
module wall_collision_unit #(
  parameter int COORD_W   = 10,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 319,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 239,
  parameter int BALL_SIZE = 4,
  parameter int HOLDOFF   = 2,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  wall_collision_unit_if.slave  bus
);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam int EXT_W  = COORD_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLD, S_LOST} state_t;

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [CNT_W-1:0]   hit_cnt, hit_nxt;
  logic               left_q, right_q, top_q, miss_q, lost_q;
  logic               left_nxt, right_nxt, top_nxt, miss_nxt;

  // Far edges are computed one bit wider so a ball near the coordinate limit cannot wrap.
  logic [EXT_W-1:0] left_e, right_e, top_e, bottom_e;
  logic             cond_l, cond_r, cond_t, cond_b;

  always_comb begin
    left_e   = {1'b0, bus.ball_x};
    top_e    = {1'b0, bus.ball_y};
    right_e  = left_e + EXT_W'(BALL_SIZE - 1);
    bottom_e = top_e  + EXT_W'(BALL_SIZE - 1);
    cond_l   = (left_e   <= EXT_W'(X_MIN)) &  bus.dx_neg;
    cond_r   = (right_e  >= EXT_W'(X_MAX)) & ~bus.dx_neg;
    cond_t   = (top_e    <= EXT_W'(Y_MIN)) &  bus.dy_neg;
    cond_b   = (bottom_e >= EXT_W'(Y_MAX)) & ~bus.dy_neg;
  end

  // NOTE: every always_comb output gets a default before any branch, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    hit_nxt   = hit_cnt;
    left_nxt  = 1'b0;
    right_nxt = 1'b0;
    top_nxt   = 1'b0;
    miss_nxt  = 1'b0;

    if (!bus.en) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  state_nxt = S_ARMED;
        S_ARMED: begin
          if (bus.frame_tick) begin
            if (cond_b) begin
              miss_nxt  = 1'b1;
              state_nxt = S_LOST;
            end else if (cond_l | cond_r | cond_t) begin
              // Left wins when both side walls qualify.
              left_nxt  = cond_l;
              right_nxt = cond_r & ~cond_l;
              top_nxt   = cond_t;
              if (hit_cnt != {CNT_W{1'b1}}) hit_nxt = hit_cnt + CNT_W'(1);
              if (HOLDOFF != 0) begin
                hold_nxt  = HOLD_W'(HOLDOFF);
                state_nxt = S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (bus.frame_tick) begin
            if (hold_cnt <= HOLD_W'(1)) begin
              hold_nxt  = '0;
              state_nxt = S_ARMED;
            end else begin
              hold_nxt  = hold_cnt - HOLD_W'(1);
            end
          end
        end
        S_LOST: begin
          if (bus.relaunch) begin
            hit_nxt   = '0;
            state_nxt = S_ARMED;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      hit_cnt  <= '0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      top_q    <= 1'b0;
      miss_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      hit_cnt  <= hit_nxt;
      left_q   <= left_nxt;
      right_q  <= right_nxt;
      top_q    <= top_nxt;
      miss_q   <= miss_nxt;
      lost_q   <= (state_nxt == S_LOST);
    end
  end

  assign bus.left_hit    = left_q;
  assign bus.right_hit   = right_q;
  assign bus.top_hit     = top_q;
  assign bus.bottom_miss = miss_q;
  assign bus.ball_lost   = lost_q;
  assign bus.hit_count   = hit_cnt;

endmodule
